// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async FIFO: default depth and Gray/binary conversions.
// The conversions work on a wide word; callers zero-extend in and truncate out.
package async_fifo_pkg;

    localparam int unsigned DEPTH     = 8;
    localparam int unsigned PTR_W_MAX = 32;

    function automatic logic [PTR_W_MAX-1:0] bin2gray(input logic [PTR_W_MAX-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    // Zero-extended upper bits contribute nothing to the XOR.
    function automatic logic [PTR_W_MAX-1:0] gray2bin(input logic [PTR_W_MAX-1:0] gray);
        logic [PTR_W_MAX-1:0] bin;
        bin = gray;
        for (int i = 1; i < PTR_W_MAX; i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_sync_ff.sv
// Multi-stage flop chain that brings a Gray-coded bus into the local clock domain.
module fifo_sync_ff #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // NOTE: sequential state uses non-blocking assignments so every stage samples the
    // pre-edge value of its neighbour; blocking here would collapse the chain to one flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/async_fifo_wptr_ctrl.sv
// Write-domain pointer and flag controller for a power-of-two async FIFO.
// All flags are computed from next-state pointers so they register with zero lag.
module async_fifo_wptr_ctrl
    import async_fifo_pkg::*;
#(
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int AF_THRESH = (2 ** ADDR_W) - 2,
    parameter int SYNC_STG  = 2
) (
    input  logic              wclk,
    input  logic              wrst_n,
    input  logic              wen,
    input  logic [ADDR_W:0]   rptr_gray,
    input  logic              ovf_clr,
    output logic [ADDR_W-1:0] waddr,
    output logic              wram_we,
    output logic [ADDR_W:0]   wptr_gray,
    output logic              wfull,
    output logic              walmost_full,
    output logic [ADDR_W:0]   wlevel,
    output logic              wovf
);

    localparam int PTR_W = ADDR_W + 1;

    logic [PTR_W-1:0] rq;
    logic [PTR_W-1:0] rq_bin;

    logic [PTR_W-1:0] wbin_q,  wbin_d;
    logic [PTR_W-1:0] wgray_q, wgray_d;
    logic [PTR_W-1:0] level_q, level_d;
    logic             full_q,  full_d;
    logic             afull_q, afull_d;
    logic             ovf_q,   ovf_d;

    logic             winc;
    logic [PTR_W-1:0] full_pattern;

    fifo_sync_ff #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STG)
    ) u_rptr_sync (
        .clk   (wclk),
        .rst_n (wrst_n),
        .d_i   (rptr_gray),
        .q_o   (rq)
    );

    assign rq_bin       = PTR_W'(gray2bin(PTR_W_MAX'(rq)));
    // Full when the write pointer has lapped the read pointer: top two Gray bits inverted.
    assign full_pattern = {~rq[ADDR_W:ADDR_W-1], rq[ADDR_W-2:0]};
    assign winc         = wen & ~full_q;

    // NOTE: every signal driven here gets a value before any condition, so no latch is inferred.
    always_comb begin
        wbin_d  = wbin_q + PTR_W'(winc);
        wgray_d = PTR_W'(bin2gray(PTR_W_MAX'(wbin_d)));
        level_d = wbin_d - rq_bin;
        full_d  = (wgray_d == full_pattern);
        afull_d = (level_d >= PTR_W'(AF_THRESH));
        ovf_d   = ovf_q;
        if (wen && full_q) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            level_q <= level_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
        end
    end

    assign waddr        = wbin_q[ADDR_W-1:0];
    assign wram_we      = winc;
    assign wptr_gray    = wgray_q;
    assign wfull        = full_q;
    assign walmost_full = afull_q;
    assign wlevel       = level_q;
    assign wovf         = ovf_q;

endmodule

// File: tb/tb_async_fifo_wptr_ctrl.sv
// Directed bench for the write-domain FIFO controller (ADDR_W=3, AF_THRESH=6, SYNC_STG=2).
module tb_async_fifo_wptr_ctrl;

    logic       wclk;
    logic       wrst_n;
    logic       wen;
    logic [3:0] rptr_gray;
    logic       ovf_clr;
    logic [2:0] waddr;
    logic       wram_we;
    logic [3:0] wptr_gray;
    logic       wfull;
    logic       walmost_full;
    logic [3:0] wlevel;
    logic       wovf;

    int checks = 0;
    int errors = 0;

    async_fifo_wptr_ctrl #(
        .ADDR_W    (3),
        .AF_THRESH (6),
        .SYNC_STG  (2)
    ) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .wen          (wen),
        .rptr_gray    (rptr_gray),
        .ovf_clr      (ovf_clr),
        .waddr        (waddr),
        .wram_we      (wram_we),
        .wptr_gray    (wptr_gray),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .wovf         (wovf)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    function automatic logic [3:0] to_gray(input int b);
        logic [3:0] x;
        x = 4'(b);
        return x ^ (x >> 1);
    endfunction

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        wen       = 1'b0;
        ovf_clr   = 1'b0;
        rptr_gray = 4'b0000;
        wrst_n    = 1'b0;
        step();
        step();
        wrst_n = 1'b1;
    endtask

    task automatic test_reset();
        wen       = 1'b0;
        ovf_clr   = 1'b0;
        rptr_gray = 4'b0000;
        wrst_n    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wen = ~wen;
            step();
        end
        checks++;
        if (waddr !== 3'd0 || wptr_gray !== 4'b0000 || wfull !== 1'b0 ||
            wlevel !== 4'd0 || wovf !== 1'b0 || walmost_full !== 1'b0) begin
            errors++;
            $display("FAIL reset: waddr=%0d gray=%b full=%b level=%0d ovf=%b af=%b, required all zero",
                     waddr, wptr_gray, wfull, wlevel, wovf, walmost_full);
        end
        wen    = 1'b0;
        wrst_n = 1'b1;
    endtask

    task automatic test_fill();
        do_reset();
        wen = 1'b1;
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (wfull !== 1'b1 || wlevel !== 4'd8 || waddr !== 3'd0 || wptr_gray !== 4'b1100) begin
            errors++;
            $display("FAIL fill_8: full=%b level=%0d waddr=%0d gray=%b, required 1 8 0 1100",
                     wfull, wlevel, waddr, wptr_gray);
        end
        checks++;
        if (wram_we !== 1'b0) begin
            errors++;
            $display("FAIL we_when_full: wram_we=%b, required 0", wram_we);
        end
        step();
        checks++;
        if (wptr_gray !== 4'b1100 || waddr !== 3'd0 || wovf !== 1'b1 || wfull !== 1'b1) begin
            errors++;
            $display("FAIL write_9th: gray=%b waddr=%0d ovf=%b full=%b, required 1100 0 1 1",
                     wptr_gray, waddr, wovf, wfull);
        end
        wen = 1'b0;
    endtask

    // Continues from the full state left by test_fill.
    task automatic test_release();
        rptr_gray = 4'b0010;
        step();
        checks++;
        if (wfull !== 1'b1) begin
            errors++;
            $display("FAIL release_edge1: wfull=%b, required 1", wfull);
        end
        step();
        checks++;
        if (wfull !== 1'b1 || wlevel !== 4'd8) begin
            errors++;
            $display("FAIL release_edge2: wfull=%b level=%0d, required 1 8", wfull, wlevel);
        end
        step();
        checks++;
        if (wfull !== 1'b0 || wlevel !== 4'd5 || walmost_full !== 1'b0) begin
            errors++;
            $display("FAIL release_edge3: wfull=%b level=%0d af=%b, required 0 5 0",
                     wfull, wlevel, walmost_full);
        end
    endtask

    task automatic test_almost_full();
        do_reset();
        wen = 1'b1;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (walmost_full !== 1'b0 || wlevel !== 4'd5) begin
            errors++;
            $display("FAIL af_5: af=%b level=%0d, required 0 5", walmost_full, wlevel);
        end
        step();
        checks++;
        if (walmost_full !== 1'b1 || wlevel !== 4'd6 || wfull !== 1'b0) begin
            errors++;
            $display("FAIL af_6: af=%b level=%0d full=%b, required 1 6 0",
                     walmost_full, wlevel, wfull);
        end
        wen = 1'b0;
    endtask

    task automatic test_wrap();
        logic [3:0] exp_gray;
        do_reset();
        wen = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            exp_gray = to_gray(i % 16);
            checks++;
            if (wptr_gray !== exp_gray || wfull !== 1'b0 || wovf !== 1'b0) begin
                errors++;
                $display("FAIL wrap_%0d: gray=%b full=%b ovf=%b, required %b 0 0",
                         i, wptr_gray, wfull, wovf, exp_gray);
            end
            rptr_gray = (i >= 4) ? to_gray((i - 4) % 16) : 4'b0000;
        end
        checks++;
        if (waddr !== 3'd4) begin
            errors++;
            $display("FAIL wrap_addr: waddr=%0d, required 4", waddr);
        end
        wen = 1'b0;
    endtask

    task automatic test_ovf_reset();
        do_reset();
        wen = 1'b1;
        for (int i = 0; i < 9; i++) step();
        checks++;
        if (wovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: wovf=%b, required 1", wovf);
        end
        ovf_clr = 1'b1;
        step();
        checks++;
        if (wovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins: wovf=%b, required 1", wovf);
        end
        wen = 1'b0;
        step();
        checks++;
        if (wovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: wovf=%b, required 0", wovf);
        end
        ovf_clr = 1'b0;
        wen     = 1'b1;
        step();
        wen = 1'b0;
        #2;
        wrst_n = 1'b0;
        #1;
        checks++;
        if (waddr !== 3'd0 || wptr_gray !== 4'b0000 || wfull !== 1'b0 || walmost_full !== 1'b0 ||
            wlevel !== 4'd0 || wovf !== 1'b0 || wram_we !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: waddr=%0d gray=%b full=%b af=%b level=%0d ovf=%b we=%b, required all zero",
                     waddr, wptr_gray, wfull, walmost_full, wlevel, wovf, wram_we);
        end
        rptr_gray = 4'b0000;
        wrst_n    = 1'b1;
        wen       = 1'b1;
        #1;
        checks++;
        if (wram_we !== 1'b1 || waddr !== 3'd0) begin
            errors++;
            $display("FAIL post_reset_write: we=%b waddr=%0d, required 1 0", wram_we, waddr);
        end
        step();
        wen = 1'b0;
        checks++;
        if (waddr !== 3'd1 || wptr_gray !== 4'b0001 || wlevel !== 4'd1) begin
            errors++;
            $display("FAIL post_reset_ptr: waddr=%0d gray=%b level=%0d, required 1 0001 1",
                     waddr, wptr_gray, wlevel);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_release();
        test_almost_full();
        test_wrap();
        test_ovf_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
